// File: rtl/piso_reg_4b.sv
// Parallel-in, serial-out shift register: loads a word on LOAD, then shifts it
// out one bit per clock in the order selected by MSB_FIRST, filling with zeros.
module piso_reg_4b #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] D_in,
   output logic             serial_out
);

   logic [WIDTH-1:0] sreg;

   // Moves the next bit toward the output end; the vacated position reads 0.
   function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] cur);
      logic [WIDTH-1:0] nxt;
      if (MSB_FIRST)
         nxt = cur << 1;
      else
         nxt = cur >> 1;
      return nxt;
   endfunction

   always_ff @(posedge clk) begin
      if (rst)
         sreg <= '0;
      else if (LOAD)
         sreg <= D_in;
      else
         sreg <= shift_step(sreg);
   end

   // Output taken straight from the register so no input reaches it combinationally.
   assign serial_out = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

endmodule

// File: tb/tb_piso_reg_4b.sv
// Directed bench for piso_reg_4b: MSB-first and LSB-first instances share
// clock, reset and load inputs; expected serial bits are hand-computed.
module tb_piso_reg_4b;

   logic       clk = 1'b0;
   logic       rst;
   logic       LOAD;
   logic [3:0] D_in;
   logic       so_msb;
   logic       so_lsb;
   int         checks   = 0;
   int         failures = 0;

   piso_reg_4b #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst(rst), .LOAD(LOAD), .D_in(D_in), .serial_out(so_msb)
   );

   piso_reg_4b #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .LOAD(LOAD), .D_in(D_in), .serial_out(so_lsb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Apply inputs, take one rising edge, then sample 1 time unit later.
   task automatic edge_step(input logic r, input logic ld, input logic [3:0] d);
      rst  = r;
      LOAD = ld;
      D_in = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; LOAD = 1'b0; D_in = 4'h0;
      #1;

      // Reset, then idle.
      edge_step(1'b1, 1'b0, 4'h0);
      check("reset_msb", so_msb, 1'b0);
      check("reset_lsb", so_lsb, 1'b0);
      for (int i = 0; i < 3; i++) begin
         edge_step(1'b0, 1'b0, 4'h0);
         check($sformatf("idle_%0d", i), so_msb, 1'b0);
      end

      // 4'hB held on LOAD for two edges, then four shifts.
      edge_step(1'b0, 1'b1, 4'hB); check("b_load0", so_msb, 1'b1);
      edge_step(1'b0, 1'b1, 4'hB); check("b_load1", so_msb, 1'b1);
      edge_step(1'b0, 1'b0, 4'h0); check("b_sh1",   so_msb, 1'b0);
      edge_step(1'b0, 1'b0, 4'h5); check("b_sh2",   so_msb, 1'b1);
      edge_step(1'b0, 1'b0, 4'hF); check("b_sh3",   so_msb, 1'b1);
      edge_step(1'b0, 1'b0, 4'hF); check("b_sh4",   so_msb, 1'b0);

      // 4'h7 held for two edges, then four shifts.
      edge_step(1'b0, 1'b1, 4'h7); check("7_load0", so_msb, 1'b0);
      edge_step(1'b0, 1'b1, 4'h7); check("7_load1", so_msb, 1'b0);
      edge_step(1'b0, 1'b0, 4'h0); check("7_sh1",   so_msb, 1'b1);
      edge_step(1'b0, 1'b0, 4'h0); check("7_sh2",   so_msb, 1'b1);
      edge_step(1'b0, 1'b0, 4'h0); check("7_sh3",   so_msb, 1'b1);
      edge_step(1'b0, 1'b0, 4'h0); check("7_sh4",   so_msb, 1'b0);
      edge_step(1'b0, 1'b0, 4'h0); check("7_fill",  so_msb, 1'b0);

      // Mid-word reload: 4'hF aborted by 4'h8.
      edge_step(1'b0, 1'b1, 4'hF); check("f_load",  so_msb, 1'b1);
      edge_step(1'b0, 1'b0, 4'h0); check("f_sh1",   so_msb, 1'b1);
      edge_step(1'b0, 1'b0, 4'h0); check("f_sh2",   so_msb, 1'b1);
      edge_step(1'b0, 1'b1, 4'h8); check("8_load",  so_msb, 1'b1);
      edge_step(1'b0, 1'b0, 4'h0); check("8_sh1",   so_msb, 1'b0);
      edge_step(1'b0, 1'b0, 4'h0); check("8_sh2",   so_msb, 1'b0);
      edge_step(1'b0, 1'b0, 4'h0); check("8_sh3",   so_msb, 1'b0);
      edge_step(1'b0, 1'b0, 4'h0); check("8_sh4",   so_msb, 1'b0);

      // Reset mid-word with LOAD high: reset wins.
      edge_step(1'b0, 1'b1, 4'hF); check("rf_load", so_msb, 1'b1);
      edge_step(1'b0, 1'b0, 4'h0); check("rf_sh1",  so_msb, 1'b1);
      edge_step(1'b1, 1'b1, 4'hF); check("rf_rst",  so_msb, 1'b0);
      check("rf_rst_lsb", so_lsb, 1'b0);
      edge_step(1'b0, 1'b0, 4'hF); check("rf_idle1", so_msb, 1'b0);
      edge_step(1'b0, 1'b0, 4'hF); check("rf_idle2", so_msb, 1'b0);

      // LSB-first instance: 4'hB streams 1,1,0,1 then 0.
      edge_step(1'b0, 1'b1, 4'hB); check("lsb_load", so_lsb, 1'b1);
      edge_step(1'b0, 1'b0, 4'h0); check("lsb_sh1",  so_lsb, 1'b1);
      edge_step(1'b0, 1'b0, 4'h0); check("lsb_sh2",  so_lsb, 1'b0);
      edge_step(1'b0, 1'b0, 4'h0); check("lsb_sh3",  so_lsb, 1'b1);
      edge_step(1'b0, 1'b0, 4'h0); check("lsb_sh4",  so_lsb, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/piso_reg_4b.md
# piso_reg_4b

Parallel-in, serial-out shift register. It captures a 4-bit word on a load command and then shifts it out one bit per clock, MSB first, on a single serial line. It sits between a parallel data source and a bit-serial consumer, such as a serial transmitter front end. It has no handshake: the upstream controller owns the timing of LOAD.

## Interface
Parameters:
- WIDTH, default 4: word width in bits. The module name assumes 4; other values are supported without RTL changes.
- MSB_FIRST, default 1: shift order.
  - 1: serial_out is the register MSB; the register shifts left.
  - 0: serial_out is the LSB; the register shifts right.

Ports:
- clk  input  1: single clock; all state updates on the rising edge.
- rst  input  1: reset, synchronous and active-high; clears the register.
- LOAD  input  1: 1 loads D_in on the next edge; 0 shifts on the next edge.
- D_in  input  WIDTH: parallel data word; sampled only when LOAD=1.
- serial_out  output  WIDTH-independent 1 bit: current serial bit, taken directly from the register (no combinational path from any input).

## Operation
- Internal state is a WIDTH-bit shift register, sreg.
- Priority on each rising clk edge:
  1. rst=1: sreg <= 0.
  2. Else LOAD=1: sreg <= D_in.
  3. Else, shift:
     - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], 1'b0}.
     - MSB_FIRST=0: sreg <= {1'b0, sreg[WIDTH-1:1]}.
- serial_out = sreg[WIDTH-1] when MSB_FIRST=1, sreg[0] otherwise.
- Vacated positions fill with 0. After WIDTH shift cycles with no reload, serial_out stays 0 until the next load.
- LOAD held high for several cycles reloads D_in every cycle. serial_out shows the first bit of the current D_in for the whole time LOAD is high.
- LOAD asserted mid-word aborts the word in progress; the new word replaces it on that edge.
- D_in changes while LOAD=0 have no effect.
- There is no busy or done output. The controller counts WIDTH shift cycles itself.

## Timing
- Reset value: sreg = 0, serial_out = 0 (after the first edge with rst=1). Before the first reset or load, the output is undefined; benches apply reset first.
- Load latency: the first serial bit (D_in MSB for MSB_FIRST=1) is valid on serial_out right after the load edge. No extra cycle is needed.
- Bit k (k = 0 being the first bit out) is valid after the k-th shift edge that follows the last load edge. The full word needs the load edge plus WIDTH-1 shift edges.
- The last bit stays valid until the WIDTH-th shift edge, which drives 0.
- Reset mid-word: the output is 0 after that edge, and the word is discarded.
- rst and LOAD both high: reset wins.

## Test plan
- Reset, then idle with LOAD=0 -> serial_out = 0 on every edge.
- D_in=4'hB, LOAD=1 for 2 edges, then LOAD=0 for 4 edges -> serial_out = 1,1 during load, then 0,1,1,0 after the shift edges. The full sequence after the first load edge is 1,0,1,1 from the last load edge, followed by fill 0.
- Continuing the previous case, D_in=4'h7, LOAD=1 for 2 edges, then LOAD=0 for 4 edges -> serial_out = 0,0 during load, then 1,1,1,0.
- Load 4'hF, shift 2 edges, then load 4'h8 -> serial_out = 1,1,1, then 1,0,0,0,0. The new word fully replaces the old one.
- Load 4'hF, shift 1 edge, then assert rst for 1 edge with LOAD=1 -> serial_out = 0, and it stays 0 with LOAD=0.
- MSB_FIRST=0, load 4'hB -> serial_out = 1,1,0,1, then 0.
